// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU operation codes and forwarding
// mux selects used by the execute stage and the hazard logic.
package riscv_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forwarding_unit_module.sv
// Combinational RAW-hazard bypass selection for the two EX source operands.
// MEM wins over WB, and register x0 never forwards.
module forwarding_unit_module
   import riscv_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] RS1_E,
   input  logic [REG_AW-1:0] RS2_E,
   input  logic [REG_AW-1:0] RdM,
   input  logic              RegWriteM,
   input  logic [REG_AW-1:0] RdW,
   input  logic              RegWriteW,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE
);

   logic memValid;
   logic wbValid;

   assign memValid = RegWriteM && (RdM != '0);
   assign wbValid  = RegWriteW && (RdW != '0);

   always_comb begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      if (memValid && (RdM == RS1_E)) begin
         ForwardAE = FWD_MEM;
      end else if (wbValid && (RdW == RS1_E)) begin
         ForwardAE = FWD_WB;
      end
      if (memValid && (RdM == RS2_E)) begin
         ForwardBE = FWD_MEM;
      end else if (wbValid && (RdW == RS2_E)) begin
         ForwardBE = FWD_WB;
      end
   end

endmodule

// File: rtl/execute_stage_module.sv
// Execute stage: operand bypass, ALU, beq branch resolution and the EX/MEM
// pipeline register feeding the memory stage.
module execute_stage_module
   import riscv_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegWriteE,
   input  logic              ResultSrcE,
   input  logic              MemWriteE,
   input  logic              BranchE,
   input  logic              ALUSrcE,
   input  logic [2:0]        ALUControlE,
   input  logic [WIDTH-1:0]  RD1_E,
   input  logic [WIDTH-1:0]  RD2_E,
   input  logic [WIDTH-1:0]  ImmExtE,
   input  logic [WIDTH-1:0]  PCE,
   input  logic [WIDTH-1:0]  PCPlus4E,
   input  logic [REG_AW-1:0] RS1_E,
   input  logic [REG_AW-1:0] RS2_E,
   input  logic [REG_AW-1:0] RdE,
   input  logic              RegWriteW,
   input  logic [REG_AW-1:0] RdW,
   input  logic [WIDTH-1:0]  ResultW,
   output logic              PCSrcE,
   output logic [WIDTH-1:0]  PCTargetE,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              RegWriteM,
   output logic              ResultSrcM,
   output logic              MemWriteM,
   output logic [WIDTH-1:0]  ALUResultM,
   output logic [WIDTH-1:0]  WriteDataM,
   output logic [WIDTH-1:0]  PCPlus4M,
   output logic [REG_AW-1:0] RdM
);

   logic [WIDTH-1:0]  srcAE;
   logic [WIDTH-1:0]  srcBE;
   logic [WIDTH-1:0]  writeDataE;
   logic [WIDTH-1:0]  aluResultE;
   logic              zeroE;

   logic              regWrite_q,  regWrite_d;
   logic              resultSrc_q, resultSrc_d;
   logic              memWrite_q,  memWrite_d;
   logic [WIDTH-1:0]  aluResult_q, aluResult_d;
   logic [WIDTH-1:0]  writeData_q, writeData_d;
   logic [WIDTH-1:0]  pcPlus4_q,   pcPlus4_d;
   logic [REG_AW-1:0] rd_q,        rd_d;

   // Bypass decisions look at the stage's own registered destination.
   forwarding_unit_module #(
      .REG_AW(REG_AW)
   ) u_forwarding (
      .RS1_E    (RS1_E),
      .RS2_E    (RS2_E),
      .RdM      (rd_q),
      .RegWriteM(regWrite_q),
      .RdW      (RdW),
      .RegWriteW(RegWriteW),
      .ForwardAE(ForwardAE),
      .ForwardBE(ForwardBE)
   );

   always_comb begin
      srcAE      = RD1_E;
      writeDataE = RD2_E;
      case (ForwardAE)
         FWD_WB:  srcAE = ResultW;
         FWD_MEM: srcAE = aluResult_q;
         default: srcAE = RD1_E;
      endcase
      case (ForwardBE)
         FWD_WB:  writeDataE = ResultW;
         FWD_MEM: writeDataE = aluResult_q;
         default: writeDataE = RD2_E;
      endcase
      srcBE = ALUSrcE ? ImmExtE : writeDataE;
   end

   // Unlisted operation codes deliberately yield zero.
   always_comb begin
      aluResultE = '0;
      case (ALUControlE)
         ALU_ADD: aluResultE = srcAE + srcBE;
         ALU_SUB: aluResultE = srcAE - srcBE;
         ALU_AND: aluResultE = srcAE & srcBE;
         ALU_OR:  aluResultE = srcAE | srcBE;
         ALU_SLT: aluResultE = {{(WIDTH-1){1'b0}}, ($signed(srcAE) < $signed(srcBE))};
         default: aluResultE = '0;
      endcase
   end

   assign zeroE     = (aluResultE == '0);
   assign PCSrcE    = BranchE & zeroE;
   assign PCTargetE = PCE + ImmExtE;

   always_comb begin
      regWrite_d  = RegWriteE;
      resultSrc_d = ResultSrcE;
      memWrite_d  = MemWriteE;
      aluResult_d = aluResultE;
      writeData_d = writeDataE;
      pcPlus4_d   = PCPlus4E;
      rd_d        = RdE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regWrite_q  <= 1'b0;
         resultSrc_q <= 1'b0;
         memWrite_q  <= 1'b0;
         aluResult_q <= '0;
         writeData_q <= '0;
         pcPlus4_q   <= '0;
         rd_q        <= '0;
      end else begin
         regWrite_q  <= regWrite_d;
         resultSrc_q <= resultSrc_d;
         memWrite_q  <= memWrite_d;
         aluResult_q <= aluResult_d;
         writeData_q <= writeData_d;
         pcPlus4_q   <= pcPlus4_d;
         rd_q        <= rd_d;
      end
   end

   assign RegWriteM  = regWrite_q;
   assign ResultSrcM = resultSrc_q;
   assign MemWriteM  = memWrite_q;
   assign ALUResultM = aluResult_q;
   assign WriteDataM = writeData_q;
   assign PCPlus4M   = pcPlus4_q;
   assign RdM        = rd_q;

endmodule
